bist_lfsr_misr_ctrl: RTL
========================

// Module: bist_lfsr_misr_ctrl
// PURPOSE
//  Built-in self-test controller for the gate-level primitive netlists (inv/and/nand/xor/nor/or cells).
//  Upstream stage: a Galois LFSR drives pseudo-random patterns into the circuit-under-test (CUT).
//  Downstream stage: a MISR compacts the CUT responses into a signature, compared with a golden value.
//  Used for trojan / fault screening of structural logic without external vectors.
// PARAMETERS
//  PAT_W      16        width of pattern_out / LFSR
//  RESP_W     16        width of resp_in / MISR / signature
//  LFSR_SEED  16'hACE1  LFSR load value at start; a value of 0 is replaced by 1
//  LFSR_TAPS  16'hB400  Galois feedback mask for the LFSR (PAT_W bits)
//  MISR_TAPS  16'hB400  Galois feedback mask for the MISR (RESP_W bits)
//  PAT_CNT    1024      patterns per run, 1..2^CNT_W-1
//  CNT_W      16        pattern counter width
//  LATENCY    1         CUT pipeline depth in cycles, 0..7
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       one-cycle pulse, begins a run
//  golden_sig   in   RESP_W  expected signature; must be stable while done=1
//  pattern_out  out  PAT_W   pattern to CUT
//  pattern_valid out 1       pattern_out is a live pattern this cycle
//  resp_in      in   RESP_W  CUT response, aligned LATENCY cycles after its pattern
//  busy         out  1       high in RUN and DRAIN
//  done         out  1       high in DONE
//  pass         out  1       done && (signature == golden_sig)
//  signature    out  RESP_W  current MISR register value
// BEHAVIOUR
//  - Reset: state=IDLE; pattern_out=0, pattern_valid=0, busy=0, done=0, pass=0, signature=0.
//    The valid delay line and the counter clear. Reset mid-run aborts immediately.
//  - Galois step g(x, T): (x >> 1) ^ (x[0] ? T : 0).
//  - FSM states: IDLE -> RUN -> DRAIN -> DONE.
//    IDLE: start=1 -> load LFSR=LFSR_SEED, MISR=0, cnt=0; next state RUN.
//    RUN: pattern_out=LFSR, pattern_valid=1. Each cycle LFSR<=g(LFSR, LFSR_TAPS) and cnt++.
//      When cnt==PAT_CNT-1, go to DRAIN; if LATENCY==0, go straight to DONE.
//    DRAIN: pattern_valid=0, pattern_out holds its last value. Stay LATENCY cycles, then go to DONE.
//    DONE: done=1. start=1 -> restart, same as the IDLE start action. Otherwise hold.
//    start in RUN or DRAIN is ignored.
//  - Timing: start sampled at edge T -> first pattern (= seed) visible after edge T. done rises after edge T+PAT_CNT+LATENCY.
//  - MISR capture: a LATENCY-deep delay line of pattern_valid, vd.
//    On each edge where vd is high: MISR <= g(MISR, MISR_TAPS) ^ resp_in.
//    With LATENCY=0, capture uses pattern_valid directly, and resp_in may be combinational from pattern_out.
//    Exactly PAT_CNT captures per run. The last capture lands on the edge entering DONE.
//  - pass is combinational from registered signature and golden_sig, gated by done.
//  - Counter is CNT_W bits wide and never wraps within a run. The LFSR never reaches 0 because the seed is forced nonzero.
// TESTING
//  1 Defaults. Pulse start, observe first 3 patterns -> 0xACE1, 0xE270, 0x7138; pattern_valid=1 for exactly 1024 cycles.
//  2 PAT_CNT=4, LATENCY=1, resp_in tied to 0 -> done rises 5 cycles after start, signature=0x0000;
//    golden 0x0000 -> pass=1; golden 0x0001 -> pass=0.
//  3 PAT_CNT=1, LATENCY=0, resp_in=pattern_out -> one capture: signature=0xACE1, done 1 cycle after start.
//  4 Loopback via a 1-cycle register, PAT_CNT=2, LATENCY=1 -> MISR=g(0xACE1)^0xE270=0x0000, pass with golden 0x0000.
//    Flip one response bit -> pass=0.
//  5 Assert rst on the 3rd RUN cycle -> next cycle all outputs 0, state IDLE. Later start reproduces scenario 1 from the seed.
//  6 start pulses during RUN and DRAIN are ignored (timing unchanged). start in DONE restarts: done=0 and busy=1 next cycle.

Source files
------------

// File: rtl/bist_lfsr_misr_ctrl.sv
// BIST controller: a Galois LFSR drives patterns into the circuit under test and a
// Galois MISR compacts its responses into a signature that is compared with a golden value.
module bist_lfsr_misr_ctrl #(
    parameter int                PAT_W     = 16,
    parameter int                RESP_W    = 16,
    parameter logic [PAT_W-1:0]  LFSR_SEED = 16'hACE1,
    parameter logic [PAT_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter logic [RESP_W-1:0] MISR_TAPS = 16'hB400,
    parameter int                PAT_CNT   = 1024,
    parameter int                CNT_W     = 16,
    parameter int                LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RESP_W-1:0] golden_sig,
    output logic [PAT_W-1:0]  pattern_out,
    output logic              pattern_valid,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [RESP_W-1:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [PAT_W-1:0] SEED_NZ = (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;
    localparam int               VD_W    = (LATENCY > 0) ? LATENCY : 1;

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    lfsr_q;
    logic [RESP_W-1:0]   misr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          drain_q;
    logic [VD_W-1:0]     vd_q;
    logic                load;
    logic                last_pat;
    logic                drain_last;
    logic                cap_en;

    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [RESP_W-1:0] misr_step(input logic [RESP_W-1:0] x);
        return (x >> 1) ^ (x[0] ? MISR_TAPS : '0);
    endfunction

    assign last_pat   = (cnt_q == CNT_W'(PAT_CNT - 1));
    assign drain_last = (drain_q == 3'(LATENCY - 1));
    assign cap_en     = (LATENCY == 0) ? pattern_valid : vd_q[VD_W-1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // otherwise a missed branch would infer a latch.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        pattern_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pattern_valid = 1'b1;
                busy          = 1'b1;
                if (last_pat) begin
                    state_d = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The LFSR doubles as the pattern register: it holds on the final RUN cycle so
    // pattern_out keeps the last pattern through DRAIN and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            vd_q    <= '0;
        end else begin
            vd_q <= (vd_q << 1) | VD_W'(pattern_valid);
            if (load) begin
                lfsr_q  <= SEED_NZ;
                misr_q  <= '0;
                cnt_q   <= '0;
                drain_q <= '0;
            end else begin
                if (state_q == ST_RUN) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!last_pat) begin
                        lfsr_q <= lfsr_step(lfsr_q);
                    end
                end
                if (state_q == ST_DRAIN) begin
                    drain_q <= drain_q + 1'b1;
                end
                if (cap_en) begin
                    misr_q <= misr_step(misr_q) ^ resp_in;
                end
            end
        end
    end

    assign pattern_out = lfsr_q;
    assign signature   = misr_q;
    assign pass        = done && (misr_q == golden_sig);

endmodule
